// File: rtl/alu_sys_pkg.sv
// ----------------------------------------------------------------------------
// alu_sys_pkg
//   Shared definitions for the ALU command path:
//     - command header bytes that open a frame on the RX byte stream
//     - ALU function codes carried in the low nibble of the FUN byte
//     - state encoding of the command controller FSM
//     - small helper used to classify FSM states
// ----------------------------------------------------------------------------
package alu_sys_pkg;

    // Frame header bytes
    localparam logic [7:0] CMD_OPS = 8'hCC;  // header, A, B, FUN
    localparam logic [7:0] CMD_FUN = 8'hDD;  // header, FUN (reuse stored A/B)

    // ALU function codes (only FUN[3:0] reaches the ALU)
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_NOT = 4'b0110;
    localparam logic [3:0] ALU_INC = 4'b0111;
    localparam logic [3:0] ALU_DEC = 4'b1000;
    localparam logic [3:0] ALU_SHR = 4'b1101;
    localparam logic [3:0] ALU_SHL = 4'b1110;

    // Command controller states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GET_A   = 3'd1,
        S_GET_B   = 3'd2,
        S_GET_FUN = 3'd3,
        S_REQ     = 3'd4,
        S_WAIT    = 3'd5,
        S_TX_LO   = 3'd6,
        S_TX_HI   = 3'd7
    } state_t;

    // True while an operation is in flight or its result is being returned;
    // RX bytes arriving in these states cannot be accepted.
    function automatic logic is_busy(input state_t s);
        return (s == S_REQ) || (s == S_WAIT) || (s == S_TX_LO) || (s == S_TX_HI);
    endfunction

endpackage

// File: rtl/alu_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// alu_cmd_ctrl
//   Command-side initiator for the system ALU. Parses frames from the RX byte
//   stream, drives the ALU operand/function/enable inputs, captures the ALU
//   result and returns it as two bytes (low byte first) over a valid/ready
//   transmit interface.
//
// Ports
//   clk         in   1       system clock, rising edge
//   rst         in   1       asynchronous reset, active low
//   rx_data     in   DATA_W  received byte
//   rx_vld      in   1       rx_data valid, one-cycle pulse per byte
//   alu_a       out  OP_W    ALU operand A (registered, zero-extended byte)
//   alu_b       out  OP_W    ALU operand B (registered, zero-extended byte)
//   alu_fun     out  4       ALU function code (registered)
//   alu_en      out  1       ALU enable, one cycle per operation
//   alu_clk_en  out  1       ALU clock-gate enable, S_REQ through S_WAIT
//   alu_out     in   OUT_W   ALU result
//   alu_valid   in   1       ALU result valid (honoured only in S_WAIT)
//   tx_data     out  DATA_W  result byte to transmitter
//   tx_vld      out  1       tx_data valid, held until tx_ready
//   tx_ready    in   1       transmitter accepts when tx_vld & tx_ready
//   frame_err   out  1       one-cycle pulse: bad header byte or ALU timeout
//   overrun     out  1       one-cycle pulse: RX byte dropped while busy
// ----------------------------------------------------------------------------
module alu_cmd_ctrl
    import alu_sys_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int OP_W     = 9,
    parameter int OUT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_vld,
    output logic [OP_W-1:0]   alu_a,
    output logic [OP_W-1:0]   alu_b,
    output logic [3:0]        alu_fun,
    output logic              alu_en,
    output logic              alu_clk_en,
    input  logic [OUT_W-1:0]  alu_out,
    input  logic              alu_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_vld,
    input  logic              tx_ready,
    output logic              frame_err,
    output logic              overrun
);

    // Counter must be able to hold WAIT_MAX-1, the value on the last
    // permitted S_WAIT cycle.
    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic               wait_done;
    logic [OUT_W-1:0]   res;
    logic               is_ops;
    logic               is_fun;
    logic               frame_err_nxt;
    logic               overrun_nxt;

    assign is_ops    = (rx_data == DATA_W'(CMD_OPS));
    assign is_fun    = (rx_data == DATA_W'(CMD_FUN));
    // The counter starts at 0 on the first S_WAIT cycle, so WAIT_MAX-1 marks
    // the final cycle: S_WAIT lasts at most WAIT_MAX cycles.
    assign wait_done = (wait_cnt == CNT_W'(WAIT_MAX - 1));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (rx_vld) begin
                    if (is_ops) begin
                        state_nxt = S_GET_A;
                    end else if (is_fun) begin
                        state_nxt = S_GET_FUN;
                    end
                end
            end
            S_GET_A: begin
                if (rx_vld) state_nxt = S_GET_B;
            end
            S_GET_B: begin
                if (rx_vld) state_nxt = S_GET_FUN;
            end
            S_GET_FUN: begin
                if (rx_vld) state_nxt = S_REQ;
            end
            S_REQ: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A result on the final cycle still wins over the timeout.
                if (alu_valid) begin
                    state_nxt = S_TX_LO;
                end else if (wait_done) begin
                    state_nxt = S_IDLE;
                end
            end
            S_TX_LO: begin
                if (tx_ready) state_nxt = S_TX_HI;
            end
            S_TX_HI: begin
                if (tx_ready) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        alu_en        = 1'b0;
        alu_clk_en    = 1'b0;
        tx_vld        = 1'b0;
        tx_data       = '0;
        frame_err_nxt = 1'b0;
        overrun_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                frame_err_nxt = rx_vld && !is_ops && !is_fun;
            end
            S_REQ: begin
                alu_en     = 1'b1;
                alu_clk_en = 1'b1;
            end
            S_WAIT: begin
                alu_clk_en    = 1'b1;
                frame_err_nxt = !alu_valid && wait_done;
            end
            S_TX_LO: begin
                tx_vld  = 1'b1;
                tx_data = res[DATA_W-1:0];
            end
            S_TX_HI: begin
                tx_vld  = 1'b1;
                tx_data = res[2*DATA_W-1:DATA_W];
            end
            default: begin
            end
        endcase
        // Bytes that arrive while an operation is in flight are discarded.
        overrun_nxt = rx_vld && is_busy(state);
    end

    // ------------------------------------------------------------------------
    // Operand, result, timeout and pulse registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= '0;
            res       <= '0;
            wait_cnt  <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_err_nxt;
            overrun   <= overrun_nxt;

            if (rx_vld) begin
                case (state)
                    S_GET_A:   alu_a   <= OP_W'(rx_data);
                    S_GET_B:   alu_b   <= OP_W'(rx_data);
                    S_GET_FUN: alu_fun <= rx_data[3:0];
                    default: begin
                    end
                endcase
            end

            if (state == S_REQ) begin
                wait_cnt <= '0;
            end else if ((state == S_WAIT) && !wait_done) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // res only changes on capture, so tx_data is stable while the
            // transmitter stalls.
            if ((state == S_WAIT) && alu_valid) begin
                res <= alu_out;
            end
        end
    end

endmodule
